// File: rtl/nclic_pkg.sv
// Shared constants and width helpers for the nested interrupt controller.
// Types stay local to each module; only parameters and functions live here.
package nclic_pkg;

  localparam int DefIntAmount  = 8;
  localparam int DefPriorities = 4;

  // Width of an index/counter able to hold n distinct values, never below 1.
  function automatic int clog2_safe(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  // Number of leaves in the arbitration tree: next power of two >= n.
  function automatic int tree_leaves(input int n);
    return 1 << clog2_safe(n);
  endfunction

endpackage

// File: rtl/nclic_arbiter.sv
// Combinational max-tree over (valid, prio, idx) with lowest-index tie-break.
// Ports: valid/prio per line in; any_valid, win_idx, win_prio out.
module nclic_arbiter
  import nclic_pkg::*;
#(
  parameter int IntAmount = DefIntAmount,
  parameter int IdWidth   = clog2_safe(DefIntAmount),
  parameter int PrioWidth = clog2_safe(DefPriorities)
) (
  input  logic [IntAmount-1:0]                valid,
  input  logic [IntAmount-1:0][PrioWidth-1:0] prio,
  output logic                                any_valid,
  output logic [IdWidth-1:0]                  win_idx,
  output logic [PrioWidth-1:0]                win_prio
);

  localparam int Leaves = tree_leaves(IntAmount);
  localparam int Nodes  = 2 * Leaves;

  // Heap-ordered tree: node j has children 2j (lower indices) and
  // 2j+1 (higher indices). Leaves occupy Leaves..Nodes-1.
  always_comb begin : tree
    logic                 nv [Nodes];
    logic [PrioWidth-1:0] np [Nodes];
    logic [IdWidth-1:0]   ni [Nodes];
    for (int j = 0; j < Nodes; j++) begin
      nv[j] = 1'b0;
      np[j] = '0;
      ni[j] = '0;
    end
    for (int i = 0; i < IntAmount; i++) begin
      nv[Leaves + i] = valid[i];
      np[Leaves + i] = prio[i];
      ni[Leaves + i] = IdWidth'(i);
    end
    for (int j = Leaves - 1; j >= 1; j--) begin
      // The right child wins only on a strictly higher priority, which
      // leaves ties with the lower-indexed left subtree.
      if (nv[2*j+1] && (!nv[2*j] || np[2*j+1] > np[2*j])) begin
        nv[j] = 1'b1;
        np[j] = np[2*j+1];
        ni[j] = ni[2*j+1];
      end else begin
        nv[j] = nv[2*j];
        np[j] = np[2*j];
        ni[j] = ni[2*j];
      end
    end
    any_valid = nv[1];
    win_idx   = ni[1];
    win_prio  = np[1];
  end

endmodule

// File: rtl/nclic_nested.sv
// Nested-vectored interrupt controller with a hardware preemption stack.
// Ports: line prio/pend/enable, global ie, take/mret from core; request, winner, level, depth, err.
module nclic_nested
  import nclic_pkg::*;
#(
  parameter int                 IntAmount  = DefIntAmount,
  parameter int                 Priorities = DefPriorities,
  parameter logic [IntAmount-1:0] EdgeMask = '0,
  localparam int IdWidth    = clog2_safe(IntAmount),
  localparam int PrioWidth  = clog2_safe(Priorities),
  localparam int Depth      = Priorities - 1,
  localparam int DepthWidth = clog2_safe(Depth + 1)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [IntAmount-1:0][PrioWidth-1:0] i_priorities,
  input  logic [IntAmount-1:0]                i_pendings,
  input  logic [IntAmount-1:0]                i_enables,
  input  logic                                i_global_ie,
  input  logic                                i_take,
  input  logic                                mret,
  output logic                                o_int,
  output logic [IdWidth-1:0]                  o_idx,
  output logic [PrioWidth-1:0]                o_prio,
  output logic [PrioWidth-1:0]                o_level,
  output logic [DepthWidth-1:0]               o_depth,
  output logic                                o_err
);

  logic [IntAmount-1:0] prev_q;
  logic [IntAmount-1:0] latch_q;
  logic [IntAmount-1:0] rise;
  logic [IntAmount-1:0] clr;
  logic [IntAmount-1:0] eff;
  logic [IntAmount-1:0] prio_nz;
  logic [IntAmount-1:0] cand;

  logic                 any_valid;
  logic [IdWidth-1:0]   win_idx;
  logic [PrioWidth-1:0] win_prio;

  logic take_acc;
  logic push;
  logic pop;
  logic chain;
  logic req;
  logic full;
  logic empty;

  logic [PrioWidth-1:0] stack_q [Depth];

  assign take_acc = i_take & o_int;
  assign push     = take_acc & ~mret;
  assign chain    = take_acc & mret;
  assign pop      = mret & ~take_acc;

  assign full  = (o_depth == DepthWidth'(Depth));
  assign empty = (o_depth == '0);

  always_comb begin
    prio_nz = '0;
    for (int k = 0; k < IntAmount; k++) begin
      prio_nz[k] = (i_priorities[k] != '0);
    end
  end

  assign rise = i_pendings & ~prev_q & EdgeMask;
  assign clr  = take_acc ? (IntAmount'(1) << o_idx) : '0;

  // Edge lines use their latch, level lines the raw input.
  assign eff  = (latch_q & EdgeMask) | (i_pendings & ~EdgeMask);
  assign cand = eff & i_enables & prio_nz;

  nclic_arbiter #(
    .IntAmount (IntAmount),
    .IdWidth   (IdWidth),
    .PrioWidth (PrioWidth)
  ) u_arb (
    .valid     (cand),
    .prio      (i_priorities),
    .any_valid (any_valid),
    .win_idx   (win_idx),
    .win_prio  (win_prio)
  );

  // An accepted request is dropped for one cycle so the new level
  // is in place before the next evaluation.
  assign req = i_global_ie & any_valid &
               (win_prio > o_level) & ~take_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q  <= '0;
      latch_q <= '0;
    end else begin
      prev_q  <= i_pendings;
      // Set after clear, so a fresh edge survives a same-cycle take.
      latch_q <= ((latch_q & ~clr) | rise) & EdgeMask;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_int  <= 1'b0;
      o_idx  <= '0;
      o_prio <= '0;
    end else begin
      o_int <= req;
      if (req) begin
        o_idx  <= win_idx;
        o_prio <= win_prio;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_level <= '0;
      o_depth <= '0;
      o_err   <= 1'b0;
      for (int d = 0; d < Depth; d++) begin
        stack_q[d] <= '0;
      end
    end else begin
      if (push) begin
        if (full) begin
          o_err <= 1'b1;
        end else begin
          stack_q[o_depth] <= o_level;
          o_level          <= o_prio;
          o_depth          <= o_depth + DepthWidth'(1);
        end
      end else if (chain) begin
        o_level <= o_prio;
      end else if (pop) begin
        if (empty) begin
          o_err <= 1'b1;
        end else begin
          o_level <= stack_q[o_depth - DepthWidth'(1)];
          o_depth <= o_depth - DepthWidth'(1);
        end
      end
    end
  end

endmodule
